// File: rtl/dm_pkg.sv
// ---------------------------------------------------------------------------
// dm -- debug module DMI types shared between the DTM side and the DM.
//   dtm_op_e   : DMI operation (NOP / READ / WRITE)
//   dmi_req_t  : request payload {addr[6:0], op, data[31:0]}
//   dmi_resp_t : response payload {data[31:0], resp[1:0]}
//   DTM_SUCCESS / DTM_ERR / DTM_BUSY : response status codes
// ---------------------------------------------------------------------------
package dm;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    localparam logic [1:0] DTM_SUCCESS = 2'h0;
    localparam logic [1:0] DTM_ERR     = 2'h2;
    localparam logic [1:0] DTM_BUSY    = 2'h3;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

endpackage

// File: rtl/dmi_init_pkg.sv
// ---------------------------------------------------------------------------
// dmi_init_pkg -- shared definitions for the memory-mapped DMI initiator.
//   Register selects (host address bits [3:2]), CTRL/STATUS bit positions,
//   the initiator FSM state type and a helper that recognises a real op.
// ---------------------------------------------------------------------------
package dmi_init_pkg;

    // Register selects, i.e. byte offset >> 2
    localparam logic [1:0] REG_ADDR  = 2'd0;  // 0x0
    localparam logic [1:0] REG_WDATA = 2'd1;  // 0x4
    localparam logic [1:0] REG_CTRL  = 2'd2;  // 0x8
    localparam logic [1:0] REG_RDATA = 2'd3;  // 0xC

    // CTRL (write side)
    localparam int CTRL_DMIRESET_BIT = 4;
    localparam int CTRL_CLEAR_BIT    = 8;

    // STATUS (read side); sticky resp code occupies [1:0]
    localparam int STAT_OVERRUN_BIT = 2;
    localparam int STAT_TIMEOUT_BIT = 3;
    localparam int STAT_BUSY_BIT    = 31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RST
    } state_e;

    // Only READ (1) and WRITE (2) start a transaction; 0 and 3 do nothing.
    function automatic logic is_active_op(input logic [1:0] op);
        return (op == 2'd1) || (op == 2'd2);
    endfunction

endpackage

// File: rtl/dmi_init_regs.sv
// ---------------------------------------------------------------------------
// dmi_init_regs -- host slave decode, register file and registered readback.
//   clk_i, rst_ni           : clock, async active-low reset
//   slave_*_i / slave_rdata_o : host access port (readback one cycle later)
//   busy_i                  : FSM not idle (STATUS bit 31, overrun detect)
//   rdata_we_i, rdata_i     : capture a successful DMI read result
//   resp_set_i              : response code bits to OR into the sticky code
//   timeout_set_i           : set the sticky timeout flag
//   addr_o, wdata_o         : current ADDR / WDATA contents
//   start_o, op_o           : accepted CTRL op while idle, and its op code
//   dmireset_o              : CTRL write with the dmireset bit
// ---------------------------------------------------------------------------
module dmi_init_regs
    import dmi_init_pkg::*;
#(
    parameter int BusWidth = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  slave_req_i,
    input  logic                  slave_we_i,
    input  logic [BusWidth-1:0]   slave_addr_i,
    input  logic [BusWidth/8-1:0] slave_be_i,
    input  logic [BusWidth-1:0]   slave_wdata_i,
    output logic [BusWidth-1:0]   slave_rdata_o,
    input  logic                  busy_i,
    input  logic                  rdata_we_i,
    input  logic [31:0]           rdata_i,
    input  logic [1:0]            resp_set_i,
    input  logic                  timeout_set_i,
    output logic [6:0]            addr_o,
    output logic [31:0]           wdata_o,
    output logic                  start_o,
    output logic [1:0]            op_o,
    output logic                  dmireset_o
);

    logic [6:0]  addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [1:0]  resp_q;
    logic        overrun_q;
    logic        timeout_q;
    logic [31:0] rdout_q;
    logic [31:0] rdout_d;

    logic [1:0] sel;
    logic       wr, rd, ctrl_wr, op_wr, clear_err, overrun_set;

    assign sel     = slave_addr_i[3:2];
    assign wr      = slave_req_i & slave_we_i;
    assign rd      = slave_req_i & ~slave_we_i;
    assign ctrl_wr = wr && (sel == REG_CTRL);

    // Op, dmireset live in byte 0 of CTRL, clear-errors in byte 1.
    assign op_wr       = ctrl_wr & slave_be_i[0] & is_active_op(slave_wdata_i[1:0]);
    assign start_o     = op_wr & ~busy_i;
    assign overrun_set = op_wr & busy_i;
    assign op_o        = slave_wdata_i[1:0];
    assign dmireset_o  = ctrl_wr & slave_be_i[0] & slave_wdata_i[CTRL_DMIRESET_BIT];
    assign clear_err   = ctrl_wr & slave_be_i[1] & slave_wdata_i[CTRL_CLEAR_BIT];

    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;

    // Only the low 32 register bits and address bits [3:2] are decoded.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{slave_addr_i, slave_be_i, slave_wdata_i};

    // NOTE: no latch -- every always_comb output is given a default first.
    always_comb begin
        rdout_d = '0;
        unique case (sel)
            REG_ADDR:  rdout_d[6:0] = addr_q;
            REG_WDATA: rdout_d      = wdata_q;
            REG_CTRL: begin
                rdout_d[STAT_BUSY_BIT]    = busy_i;
                rdout_d[STAT_TIMEOUT_BIT] = timeout_q;
                rdout_d[STAT_OVERRUN_BIT] = overrun_q;
                rdout_d[1:0]              = resp_q;
            end
            REG_RDATA: rdout_d      = rdata_q;
            default:   rdout_d      = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            rdout_q   <= '0;
        end else begin
            if (wr && sel == REG_ADDR && slave_be_i[0]) begin
                addr_q <= slave_wdata_i[6:0];
            end
            if (wr && sel == REG_WDATA) begin
                for (int b = 0; b < 4; b++) begin
                    if (slave_be_i[b]) wdata_q[8*b +: 8] <= slave_wdata_i[8*b +: 8];
                end
            end
            if (rdata_we_i) begin
                rdata_q <= rdata_i;
            end
            // Set terms are OR-ed after the clear, so set wins on a collision.
            resp_q    <= (clear_err ? 2'b00 : resp_q) | resp_set_i;
            overrun_q <= (overrun_q & ~clear_err) | overrun_set;
            timeout_q <= (timeout_q & ~clear_err) | timeout_set_i;
            if (rd) begin
                rdout_q <= rdout_d;
            end
        end
    end

    assign slave_rdata_o = BusWidth'(rdout_q);

endmodule

// File: rtl/dmi_bus_initiator.sv
// ---------------------------------------------------------------------------
// dmi_bus_initiator -- host-driven DMI initiator replacing the JTAG DTM.
//   Host loads ADDR/WDATA, writes CTRL.op; one DMI transaction is issued,
//   the response is captured, busy and sticky error state are reported.
//   clk_i, rst_ni        : clock, async active-low reset
//   slave_*              : host register port (see dmi_init_regs)
//   dmi_rst_no           : one-cycle active-low reset pulse to the DM
//   dmi_req_valid_o/ready_i/dmi_req_o    : DMI request channel
//   dmi_resp_valid_i/ready_o/dmi_resp_i  : DMI response channel
//   Optional macro DMI_INIT_TIMEOUT_EN: abort after TimeoutCycles cycles
//   in REQ/WAIT, flag timeout and reset the DM.
// ---------------------------------------------------------------------------
module dmi_bus_initiator
    import dmi_init_pkg::*;
#(
    parameter int BusWidth      = 32,
    parameter int TimeoutCycles = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  slave_req_i,
    input  logic                  slave_we_i,
    input  logic [BusWidth-1:0]   slave_addr_i,
    input  logic [BusWidth/8-1:0] slave_be_i,
    input  logic [BusWidth-1:0]   slave_wdata_i,
    output logic [BusWidth-1:0]   slave_rdata_o,
    output logic                  dmi_rst_no,
    output logic                  dmi_req_valid_o,
    input  logic                  dmi_req_ready_i,
    output dm::dmi_req_t          dmi_req_o,
    input  logic                  dmi_resp_valid_i,
    output logic                  dmi_resp_ready_o,
    input  dm::dmi_resp_t         dmi_resp_i
);

    if (!(BusWidth == 32 || BusWidth == 64) || TimeoutCycles < 2) begin : g_bad_params
        $error("dmi_bus_initiator: BusWidth must be 32/64 and TimeoutCycles >= 2");
    end

    state_e       state_q;
    dm::dmi_req_t req_q;
    logic         req_valid_q;
    logic         resp_ready_q;
    logic         dmi_rst_n_q;

    logic [6:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        start, dmireset;
    logic [1:0]  start_op;
    logic        busy, resp_fire, resp_accept, rdata_we, timeout_hit;
    logic [1:0]  resp_set;

    assign busy      = (state_q != ST_IDLE);
    assign resp_fire = (state_q == ST_WAIT) & dmi_resp_valid_i;
    // A dmireset in the response cycle abandons the transaction: drop it.
    assign resp_accept = resp_fire & ~dmireset;
    assign rdata_we    = resp_accept & (req_q.op == dm::DTM_READ) &
                         (dmi_resp_i.resp == dm::DTM_SUCCESS);
    assign resp_set    = (resp_accept ? dmi_resp_i.resp : 2'b00) |
                         (timeout_hit ? dm::DTM_BUSY : 2'b00);

`ifdef DMI_INIT_TIMEOUT_EN
    localparam int CntW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
    logic [CntW-1:0] cnt_q;

    // Final-cycle WAIT handshake beats the timeout; a REQ handshake does not.
    assign timeout_hit = (state_q == ST_REQ || state_q == ST_WAIT) &&
                         (cnt_q == CntW'(TimeoutCycles - 1)) && !resp_fire && !dmireset;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (state_q == ST_IDLE) begin
            cnt_q <= '0;
        end else if (state_q == ST_REQ || state_q == ST_WAIT) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    dmi_init_regs #(
        .BusWidth (BusWidth)
    ) u_regs (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .slave_req_i   (slave_req_i),
        .slave_we_i    (slave_we_i),
        .slave_addr_i  (slave_addr_i),
        .slave_be_i    (slave_be_i),
        .slave_wdata_i (slave_wdata_i),
        .slave_rdata_o (slave_rdata_o),
        .busy_i        (busy),
        .rdata_we_i    (rdata_we),
        .rdata_i       (dmi_resp_i.data),
        .resp_set_i    (resp_set),
        .timeout_set_i (timeout_hit),
        .addr_o        (reg_addr),
        .wdata_o       (reg_wdata),
        .start_o       (start),
        .op_o          (start_op),
        .dmireset_o    (dmireset)
    );

    // NOTE: every FSM register, including the request payload, has a reset
    // value so the DMI outputs are defined the moment rst_ni asserts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            req_q        <= '{addr: 7'h0, op: dm::DTM_NOP, data: 32'h0};
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b0;
            dmi_rst_n_q  <= 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (dmireset) begin
                        state_q     <= ST_RST;
                        dmi_rst_n_q <= 1'b0;
                    end else if (start) begin
                        state_q     <= ST_REQ;
                        req_q       <= '{addr: reg_addr, op: dm::dtm_op_e'(start_op), data: reg_wdata};
                        req_valid_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (dmireset || timeout_hit) begin
                        state_q     <= ST_RST;
                        req_valid_q <= 1'b0;
                        dmi_rst_n_q <= 1'b0;
                    end else if (dmi_req_ready_i) begin
                        state_q      <= ST_WAIT;
                        req_valid_q  <= 1'b0;
                        resp_ready_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (dmireset || timeout_hit) begin
                        state_q      <= ST_RST;
                        resp_ready_q <= 1'b0;
                        dmi_rst_n_q  <= 1'b0;
                    end else if (dmi_resp_valid_i) begin
                        state_q      <= ST_IDLE;
                        resp_ready_q <= 1'b0;
                    end
                end
                ST_RST: begin
                    state_q     <= ST_IDLE;
                    dmi_rst_n_q <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dmi_req_o        = req_q;
    assign dmi_req_valid_o  = req_valid_q;
    assign dmi_resp_ready_o = resp_ready_q;
    assign dmi_rst_no       = dmi_rst_n_q;

endmodule

// File: tb/tb_dmi_bus_initiator.sv
// ---------------------------------------------------------------------------
// tb_dmi_bus_initiator -- directed self-checking bench for dmi_bus_initiator.
// Expected DMI requests are queued when the host triggers an op and compared
// by a monitor whenever the DUT presents a request.
// ---------------------------------------------------------------------------
module tb_dmi_bus_initiator;
    import dm::*;

    localparam int BW = 32;
    localparam logic [3:0] A_ADDR = 4'h0, A_WDATA = 4'h4, A_CTRL = 4'h8, A_RDATA = 4'hC;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            slave_req = 1'b0, slave_we = 1'b0;
    logic [BW-1:0]   slave_addr = '0, slave_wdata = '0;
    logic [BW/8-1:0] slave_be = '1;
    logic [BW-1:0]   slave_rdata;
    logic            dmi_rst_n, req_valid, resp_ready;
    logic            req_ready = 1'b1, resp_valid = 1'b0;
    dmi_req_t        dmi_req;
    dmi_resp_t       dmi_resp = '0;

    dmi_req_t exp_q[$];
    int n_asserts = 0, n_fail = 0;
    int valid_cycles = 0, rst_low_cycles = 0;
    logic [31:0] rd;
    int snap;

    always #5 clk = ~clk;

    dmi_bus_initiator #(.BusWidth(BW), .TimeoutCycles(16)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .slave_req_i      (slave_req),
        .slave_we_i       (slave_we),
        .slave_addr_i     (slave_addr),
        .slave_be_i       (slave_be),
        .slave_wdata_i    (slave_wdata),
        .slave_rdata_o    (slave_rdata),
        .dmi_rst_no       (dmi_rst_n),
        .dmi_req_valid_o  (req_valid),
        .dmi_req_ready_i  (req_ready),
        .dmi_req_o        (dmi_req),
        .dmi_resp_valid_i (resp_valid),
        .dmi_resp_ready_o (resp_ready),
        .dmi_resp_i       (dmi_resp)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Request monitor: payload must match the queued expectation on every
    // valid cycle; a handshake retires the entry.
    always @(negedge clk) begin
        if (rst_n && req_valid) begin
            valid_cycles++;
            if (exp_q.size() > 0) check("req_payload", dmi_req, exp_q[0]);
            if (req_ready) begin
                if (exp_q.size() == 0) check("req_expected", exp_q.size(), 1);
                else void'(exp_q.pop_front());
            end
        end
        if (!dmi_rst_n) rst_low_cycles++;
    end

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        slave_req = 1'b1; slave_we = 1'b1; slave_addr = BW'(a); slave_wdata = BW'(d);
        @(posedge clk); #1;
        slave_req = 1'b0; slave_we = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        slave_req = 1'b1; slave_we = 1'b0; slave_addr = BW'(a);
        @(posedge clk); #1;
        d = slave_rdata[31:0];
        slave_req = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] v;
        bus_read(a, v);
        check(tag, v, exp);
    endtask

    task automatic wait_resp_ready();
        for (int i = 0; i < 50 && !resp_ready; i++) begin
            @(posedge clk); #1;
        end
        check("resp_ready_wait", resp_ready, 1'b1);
    endtask

    task automatic respond(input int delay, input logic [31:0] d, input logic [1:0] code);
        repeat (delay) begin @(posedge clk); #1; end
        resp_valid = 1'b1; dmi_resp = '{data: d, resp: code};
        @(posedge clk); #1;
        resp_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset state
        #12;
        check("rst_req_valid", req_valid, 1'b0);
        check("rst_resp_ready", resp_ready, 1'b0);
        check("rst_dmi_rst_n", dmi_rst_n, 1'b1);
        check("rst_req_payload", dmi_req, '0);
        check("rst_rdata", slave_rdata, '0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_reg("rst_ADDR", A_ADDR, 32'h0);
        check_reg("rst_WDATA", A_WDATA, 32'h0);
        check_reg("rst_STATUS", A_CTRL, 32'h0);
        check_reg("rst_RDATA", A_RDATA, 32'h0);

        // ---- read transaction
        bus_write(A_ADDR, 32'h11);
        exp_q.push_back('{addr: 7'h11, op: DTM_READ, data: 32'h0});
        bus_write(A_CTRL, 32'h1);
        check("req_valid_latency", req_valid, 1'b1);
        wait_resp_ready();
        respond(3, 32'h0000_0382, DTM_SUCCESS);
        check_reg("read_STATUS", A_CTRL, 32'h0);
        check_reg("read_RDATA", A_RDATA, 32'h382);

        // ---- write with 5 cycles of backpressure, ADDR rewritten while busy
        req_ready = 1'b0;
        bus_write(A_ADDR, 32'h10);
        bus_write(A_WDATA, 32'h8000_0001);
        exp_q.push_back('{addr: 7'h10, op: DTM_WRITE, data: 32'h8000_0001});
        snap = valid_cycles;
        bus_write(A_CTRL, 32'h2);
        bus_write(A_ADDR, 32'h7F);
        repeat (4) begin @(posedge clk); #1; end
        req_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_valid_cycles", valid_cycles - snap, 6);
        check("bp_handshake_done", req_valid, 1'b0);
        wait_resp_ready();
        respond(1, 32'hFFFF_FFFF, DTM_SUCCESS);
        check_reg("bp_STATUS", A_CTRL, 32'h0);
        check_reg("bp_ADDR_busy_write", A_ADDR, 32'h7F);
        check_reg("bp_RDATA_kept", A_RDATA, 32'h382);

        // ---- error response and overrun
        bus_write(A_ADDR, 32'h20);
        exp_q.push_back('{addr: 7'h20, op: DTM_READ, data: 32'h8000_0001});
        bus_write(A_CTRL, 32'h1);
        bus_write(A_CTRL, 32'h2);
        check_reg("busy_STATUS", A_CTRL, 32'h8000_0004);
        wait_resp_ready();
        respond(0, 32'h0000_DEAD, DTM_ERR);
        check_reg("err_STATUS", A_CTRL, 32'h6);
        check_reg("err_RDATA_kept", A_RDATA, 32'h382);
        bus_write(A_CTRL, 32'h100);
        check_reg("w1c_STATUS", A_CTRL, 32'h0);

        // ---- error set and clear in the same cycle: set wins
        exp_q.push_back('{addr: 7'h20, op: DTM_READ, data: 32'h8000_0001});
        bus_write(A_CTRL, 32'h1);
        wait_resp_ready();
        resp_valid = 1'b1; dmi_resp = '{data: 32'h55, resp: 2'h1};
        bus_write(A_CTRL, 32'h100);
        resp_valid = 1'b0;
        check_reg("setwins_STATUS", A_CTRL, 32'h1);
        bus_write(A_CTRL, 32'h100);
        check_reg("setwins_cleared", A_CTRL, 32'h0);

        // ---- dmireset while in WAIT, with a response racing it
        bus_write(A_ADDR, 32'h30);
        exp_q.push_back('{addr: 7'h30, op: DTM_READ, data: 32'h8000_0001});
        bus_write(A_CTRL, 32'h1);
        wait_resp_ready();
        snap = rst_low_cycles;
        resp_valid = 1'b1; dmi_resp = '{data: 32'h0BAD, resp: DTM_ERR};
        bus_write(A_CTRL, 32'h10);
        resp_valid = 1'b0;
        check("dmirst_low", dmi_rst_n, 1'b0);
        check("dmirst_resp_ready", resp_ready, 1'b0);
        @(posedge clk); #1;
        check("dmirst_high_again", dmi_rst_n, 1'b1);
        check("dmirst_pulse_len", rst_low_cycles - snap, 1);
        check_reg("dmirst_STATUS", A_CTRL, 32'h0);
        check_reg("dmirst_RDATA_kept", A_RDATA, 32'h382);

        // ---- dmireset from IDLE
        snap = rst_low_cycles;
        bus_write(A_CTRL, 32'h10);
        check("idle_dmirst_low", dmi_rst_n, 1'b0);
        @(posedge clk); #1;
        check("idle_dmirst_len", rst_low_cycles - snap, 1);
        check_reg("idle_dmirst_STATUS", A_CTRL, 32'h0);

`ifdef DMI_INIT_TIMEOUT_EN
        // ---- timeout: DM never responds
        exp_q.push_back('{addr: 7'h30, op: DTM_READ, data: 32'h8000_0001});
        bus_write(A_CTRL, 32'h1);
        for (int i = 0; i < 40 && dmi_rst_n; i++) begin
            @(posedge clk); #1;
        end
        check("timeout_rst_pulse", dmi_rst_n, 1'b0);
        @(posedge clk); #1;
        check_reg("timeout_STATUS", A_CTRL, 32'hB);
        bus_write(A_CTRL, 32'h100);
`endif

        // ---- asynchronous reset while a request is pending
        req_ready = 1'b0;
        bus_write(A_ADDR, 32'h55);
        bus_write(A_WDATA, 32'h1234);
        exp_q.push_back('{addr: 7'h55, op: DTM_READ, data: 32'h1234});
        bus_write(A_CTRL, 32'h1);
        @(posedge clk); #1;
        check("arst_pre_valid", req_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req_valid", req_valid, 1'b0);
        check("arst_req_payload", dmi_req, '0);
        check("arst_dmi_rst_n", dmi_rst_n, 1'b1);
        check("arst_rdata", slave_rdata, '0);
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        req_ready = 1'b1;
        @(posedge clk); #1;
        check_reg("arst_ADDR", A_ADDR, 32'h0);
        check_reg("arst_WDATA", A_WDATA, 32'h0);
        check_reg("arst_STATUS", A_CTRL, 32'h0);
        check_reg("arst_RDATA", A_RDATA, 32'h0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
